// File: rtl/adc_pkg.sv
// Shared constants, lane layout and helpers for the audio ADC capture path.
package adc_pkg;

    localparam int ADC_FRAME_W = 32;
    localparam int LANE_L_MSB  = 31;
    localparam int LANE_R_MSB  = 15;
    localparam int LANE_W      = 16;

    // Full-width stereo lane pair as it arrives in a codec frame.
    typedef struct packed {
        logic [LANE_W-1:0] left;
        logic [LANE_W-1:0] right;
    } stereo_lane_t;

    // Magnitude of a w-bit two's complement sample (sign-extended into v);
    // the most negative value clamps to 2^(w-1)-1 so it stays representable.
    function automatic logic [LANE_W-1:0] sat_abs(input logic [LANE_W-1:0] v, input int w);
        logic signed [LANE_W:0] mag;
        logic signed [LANE_W:0] lim;
        mag = v[LANE_W-1] ? -{v[LANE_W-1], v} : {v[LANE_W-1], v};
        lim = (17'sd1 <<< (w - 1)) - 17'sd1;
        return (mag > lim) ? lim[LANE_W-1:0] : mag[LANE_W-1:0];
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous show-ahead FIFO: head word is registered and valid whenever count is nonzero.
module adc_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       push_ok,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             pop_ok;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        pop_ok   = pop & ~empty;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        push_ok  = push & (~full | pop_ok);
        drop     = push & full & ~pop_ok;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        dout_d   = dout_q;
        if (count_d != '0) begin
            // New head is the incoming word when it lands on the next read slot.
            dout_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? din : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign count = count_q;

endmodule

// File: rtl/adc_capture.sv
// Audio ADC frame capture: synchronise the codec strobe, split lanes, buffer in a FIFO.
// Optional per-channel peak magnitude tracking is built when ADC_PEAK_EN is defined.
module adc_capture
    import adc_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     AUD_INIT_FINISH,
    input  logic                     AUD_ADC_FULL,
    input  logic [ADC_FRAME_W-1:0]   ADCDATA,
    output logic [SAMPLE_W-1:0]      SAMPLE_L,
    output logic [SAMPLE_W-1:0]      SAMPLE_R,
    output logic                     SAMPLE_VALID,
    input  logic                     SAMPLE_READY,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT,
    output logic                     OVERFLOW,
    input  logic                     OVF_CLR,
    output logic [SAMPLE_W-1:0]      PEAK_L,
    output logic [SAMPLE_W-1:0]      PEAK_R,
    input  logic                     PEAK_CLR
);

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_sample_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   full_prev_q, full_prev_d;
    logic                   push_req;
    logic                   overflow_q, overflow_d;
    stereo_sample_t         frame_in;
    stereo_sample_t         head;
    logic [2*SAMPLE_W-1:0]  fifo_dout;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_push_ok;
    logic                   fifo_drop;

    assign sync_d[0] = AUD_ADC_FULL;
    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    always_comb begin
        full_prev_d = sync_q[SYNC_STAGES-1];
        push_req    = sync_q[SYNC_STAGES-1] & ~full_prev_q & AUD_INIT_FINISH;
        frame_in.left  = ADCDATA[LANE_L_MSB -: SAMPLE_W];
        frame_in.right = ADCDATA[LANE_R_MSB -: SAMPLE_W];
        overflow_d  = overflow_q;
        if (OVF_CLR) begin
            overflow_d = 1'b0;
        end
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end
    end

    // All-ones reset keeps a strobe already high at reset release from looking like an edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q      <= '1;
            full_prev_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            full_prev_q <= full_prev_d;
            overflow_q  <= overflow_d;
        end
    end

    adc_sample_fifo #(
        .WIDTH (2*SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (Clk),
        .srst    (Reset),
        .push    (push_req),
        .din     (frame_in),
        .pop     (SAMPLE_READY),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (FIFO_COUNT),
        .push_ok (fifo_push_ok),
        .drop    (fifo_drop)
    );

    assign head         = fifo_dout;
    assign SAMPLE_L     = head.left;
    assign SAMPLE_R     = head.right;
    assign SAMPLE_VALID = ~fifo_empty;
    assign OVERFLOW     = overflow_q;

`ifdef ADC_PEAK_EN
    logic [SAMPLE_W-1:0] peak_l_q, peak_l_d;
    logic [SAMPLE_W-1:0] peak_r_q, peak_r_d;
    logic [LANE_W-1:0]   abs_l_full, abs_r_full;
    logic [SAMPLE_W-1:0] abs_l, abs_r;
    logic                unused_peak;

    always_comb begin
        abs_l_full = sat_abs(LANE_W'($signed(frame_in.left)), SAMPLE_W);
        abs_r_full = sat_abs(LANE_W'($signed(frame_in.right)), SAMPLE_W);
        abs_l      = abs_l_full[SAMPLE_W-1:0];
        abs_r      = abs_r_full[SAMPLE_W-1:0];
        peak_l_d   = peak_l_q;
        peak_r_d   = peak_r_q;
        if (fifo_push_ok) begin
            peak_l_d = (PEAK_CLR || (abs_l > peak_l_q)) ? abs_l : peak_l_q;
            peak_r_d = (PEAK_CLR || (abs_r > peak_r_q)) ? abs_r : peak_r_q;
        end else if (PEAK_CLR) begin
            peak_l_d = '0;
            peak_r_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end

    assign PEAK_L      = peak_l_q;
    assign PEAK_R      = peak_r_q;
    assign unused_peak = ^{ADCDATA, fifo_full, abs_l_full, abs_r_full};
`else
    logic unused_peak;
    assign PEAK_L      = '0;
    assign PEAK_R      = '0;
    assign unused_peak = ^{ADCDATA, fifo_full, fifo_push_ok, PEAK_CLR};
`endif

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: 16-bit and 12-bit instances share one stimulus stream.
module tb_adc_capture;

    localparam int DEPTH = 8;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        init = 1'b0;
    logic        full = 1'b0;
    logic        ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        peak_clr = 1'b0;
    logic [31:0] data = '0;

    logic [15:0] l16, r16, pk_l16, pk_r16;
    logic [11:0] l12, r12, pk_l12, pk_r12;
    logic        v16, v12, ovf16, ovf12;
    logic [3:0]  cnt16, cnt12;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          mc = 0;
    bit          exp_ovf = 1'b0;

    logic [31:0] vec [10] = '{32'h1234_0001, 32'h2345_0002, 32'h3456_0003, 32'h4567_0004,
                             32'h5678_0005, 32'h6789_0006, 32'h789A_0007, 32'h89AB_0008,
                             32'h9ABC_0009, 32'hABCD_000A};

    adc_capture #(.SAMPLE_W(16), .DEPTH(DEPTH), .SYNC_STAGES(2)) u_dut16 (
        .Clk(Clk), .Reset(Reset), .AUD_INIT_FINISH(init), .AUD_ADC_FULL(full),
        .ADCDATA(data), .SAMPLE_L(l16), .SAMPLE_R(r16), .SAMPLE_VALID(v16),
        .SAMPLE_READY(ready), .FIFO_COUNT(cnt16), .OVERFLOW(ovf16), .OVF_CLR(ovf_clr),
        .PEAK_L(pk_l16), .PEAK_R(pk_r16), .PEAK_CLR(peak_clr)
    );

    adc_capture #(.SAMPLE_W(12), .DEPTH(DEPTH), .SYNC_STAGES(2)) u_dut12 (
        .Clk(Clk), .Reset(Reset), .AUD_INIT_FINISH(init), .AUD_ADC_FULL(full),
        .ADCDATA(data), .SAMPLE_L(l12), .SAMPLE_R(r12), .SAMPLE_VALID(v12),
        .SAMPLE_READY(ready), .FIFO_COUNT(cnt12), .OVERFLOW(ovf12), .OVF_CLR(ovf_clr),
        .PEAK_L(pk_l12), .PEAK_R(pk_r12), .PEAK_CLR(peak_clr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #2;
    endtask

    task automatic check_state(input string name);
        chk({name, "_count16"}, 32'(cnt16), 32'(mc));
        chk({name, "_count12"}, 32'(cnt12), 32'(mc));
        chk({name, "_valid16"}, 32'(v16), 32'(mc != 0));
        chk({name, "_ovf16"}, 32'(ovf16), 32'(exp_ovf));
        chk({name, "_ovf12"}, 32'(ovf12), 32'(exp_ovf));
    endtask

    // One codec frame; rdy/pclr are asserted only during the push_req cycle.
    task automatic frame(input logic [31:0] d, input bit rdy, input bit pclr);
        bit pop;
        data = d;
        full = 1'b1;
        tick;
        tick;
        ready    = rdy;
        peak_clr = pclr;
        pop = rdy && (mc > 0);
        if (init) begin
            if ((mc < DEPTH) || pop) begin
                exp_q.push_back(d);
                mc++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        if (pop) mc--;
        tick;
        ready    = 1'b0;
        peak_clr = 1'b0;
        full     = 1'b0;
        repeat (3) tick;
    endtask

    task automatic drain(input int n);
        ready = 1'b1;
        repeat (n) begin
            tick;
            if (mc > 0) mc--;
        end
        ready = 1'b0;
    endtask

    // Monitor: every accepted head is compared against the oldest expected frame.
    always @(negedge Clk) begin
        logic [31:0] e;
        if (!Reset && v16 && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got %h%h expected none", l16, r16);
            end else begin
                e = exp_q.pop_front();
                chk("pop_l16", 32'(l16), 32'(e[31:16]));
                chk("pop_r16", 32'(r16), 32'(e[15:0]));
                chk("pop_l12", 32'(l12), 32'(e[31:20]));
                chk("pop_r12", 32'(r12), 32'(e[15:4]));
                chk("pop_valid12", 32'(v12), 32'd1);
            end
        end
    end

    initial begin
        // Reset with the strobe held high through release.
        Reset = 1'b1; init = 1'b1; full = 1'b1;
        repeat (4) tick;
        Reset = 1'b0;
        repeat (6) tick;
        check_state("t1_held");
        chk("t1_sample_l16", 32'(l16), 32'h0);
        full = 1'b0;
        repeat (4) tick;
        check_state("t1_low");

        // Single frame: lane split, truncation and one-cycle latency.
        data = 32'h8001_7FFF;
        full = 1'b1;
        tick;
        tick;
        chk("t2_valid_in_push_cycle", 32'(v16), 32'd0);
        exp_q.push_back(32'h8001_7FFF);
        mc = 1;
        tick;
        chk("t2_valid_after_push", 32'(v16), 32'd1);
        chk("t2_l16", 32'(l16), 32'h8001);
        chk("t2_r16", 32'(r16), 32'h7FFF);
        chk("t2_l12", 32'(l12), 32'h800);
        chk("t2_r12", 32'(r12), 32'h7FF);
        full = 1'b0;
        repeat (3) tick;
        check_state("t2");
        drain(1);
        check_state("t2_drained");

        // Nine frames into an 8-deep FIFO: ninth dropped, overflow sticky until cleared.
        for (int i = 0; i < 9; i++) frame(vec[i], 1'b0, 1'b0);
        check_state("t3_full");
        ovf_clr = 1'b1;
        tick;
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        check_state("t3_cleared");

        // Full FIFO with a pop in the push cycle: push accepted, order preserved.
        frame(vec[9], 1'b1, 1'b0);
        check_state("t4_push_pop_full");
        drain(8);
        check_state("t4_drained");

        // Strobes ignored while codec init is incomplete, even with a full FIFO.
        for (int i = 0; i < 8; i++) frame(vec[i], 1'b0, 1'b0);
        init = 1'b0;
        for (int i = 0; i < 3; i++) frame(vec[9], 1'b0, 1'b0);
        check_state("t5_init_low");
        drain(8);
        check_state("t5_drained");
        init = 1'b1;

        // Reset mid-operation flushes held frames.
        frame(vec[0], 1'b0, 1'b0);
        frame(vec[1], 1'b0, 1'b0);
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        exp_q.delete();
        mc = 0;
        exp_ovf = 1'b0;
        tick;
        check_state("t_reset_flush");

        // Peak magnitude tracking.
        peak_clr = 1'b1;
        tick;
        peak_clr = 1'b0;
        chk("t6_peak_cleared", 32'(pk_l16), 32'h0);
        frame(32'h8000_0003, 1'b0, 1'b0);
        frame(32'h0064_0003, 1'b0, 1'b0);
        frame(32'hFFFB_0003, 1'b0, 1'b0);
`ifdef ADC_PEAK_EN
        chk("t6_peak_l16", 32'(pk_l16), 32'h7FFF);
        chk("t6_peak_r16", 32'(pk_r16), 32'h0003);
        chk("t6_peak_l12", 32'(pk_l12), 32'h7FF);
        chk("t6_peak_r12", 32'(pk_r12), 32'h000);
`else
        chk("t6_peak_l16", 32'(pk_l16), 32'h0);
        chk("t6_peak_l12", 32'(pk_l12), 32'h0);
`endif
        frame(32'hFFFB_0003, 1'b0, 1'b1);
`ifdef ADC_PEAK_EN
        chk("t6_clr_peak_l16", 32'(pk_l16), 32'h0005);
        chk("t6_clr_peak_l12", 32'(pk_l12), 32'h001);
`else
        chk("t6_clr_peak_l16", 32'(pk_l16), 32'h0);
`endif
        check_state("t6");
        drain(4);
        check_state("t6_drained");
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
